// File: rtl/csa_resolver_pkg.sv
// Shared constants and helpers for the carry-save pair resolver.
package csa_resolver_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int unsigned steps_of(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Index register needs at least one bit even when a single step suffices.
  function automatic int unsigned idx_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/csa_resolver_chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full-adder cells.
module csa_resolver_chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] cy;

  always_comb begin
    cy    = '0;
    sum   = '0;
    cy[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]  = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = cy[CHUNK];

endmodule

// File: rtl/csa_resolver.sv
// Sequential resolver: adds a registered (sum, carry) pair CHUNK bits per cycle.
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] S1,
  input  logic [WIDTH-1:0] S2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             cout
);

  localparam int unsigned STEPS = steps_of(WIDTH, CHUNK);
  localparam int unsigned KW    = idx_width(STEPS);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, r_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d, cout_d, in_ready_d, out_valid_d;
  logic [CHUNK-1:0] sum_c;
  logic             carry_c;

  // Operand registers shift right each step, so the adder always sees the low chunk.
  csa_resolver_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (s1_q[CHUNK-1:0]),
    .b    (s2_q[CHUNK-1:0]),
    .cin  (c_q),
    .sum  (sum_c),
    .cout (carry_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      R         <= '0;
      k_q       <= '0;
      c_q       <= 1'b0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      R         <= r_d;
      k_q       <= k_d;
      c_q       <= c_d;
      cout      <= cout_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    r_d         = R;
    k_d         = k_q;
    c_d         = c_q;
    cout_d      = cout;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          s1_d       = S1;
          s2_d       = S2;
          r_d        = '0;
          k_d        = '0;
          c_d        = 1'b0;
          cout_d     = 1'b0;
          in_ready_d = 1'b0;
          state_d    = ST_ADD;
        end
      end
      ST_ADD: begin
        r_d  = R | (WIDTH'(sum_c) << (CHUNK * 32'(k_q)));
        s1_d = s1_q >> CHUNK;
        s2_d = s2_q >> CHUNK;
        c_d  = carry_c;
        k_d  = k_q + KW'(1);
        if (k_q == KW'(STEPS - 1)) begin
          cout_d      = carry_c;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csa_resolver.sv
// Directed and random checks of csa_resolver at CHUNK = 8, 1 and 32.
module tb_csa_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] S1, S2;
  logic        in_ready, out_valid, cout;
  logic [31:0] R;
  logic        rdy1, vld1, co1, rdy32, vld32, co32;
  logic [31:0] r1, r32;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csa_resolver #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .S1(S1), .S2(S2),
    .out_valid(out_valid), .out_ready(out_ready), .R(R), .cout(cout)
  );

  csa_resolver #(.WIDTH(32), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .S1(S1), .S2(S2),
    .out_valid(vld1), .out_ready(out_ready), .R(r1), .cout(co1)
  );

  csa_resolver #(.WIDTH(32), .CHUNK(32)) dut_c32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .S1(S1), .S2(S2),
    .out_valid(vld32), .out_ready(out_ready), .R(r32), .cout(co32)
  );

  // Offer a pair at the current negedge and return after the accepting edge.
  task automatic offer(input logic [31:0] a, input logic [31:0] b);
    int n;
    S1 = a;
    S2 = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen at a negedge.
  task automatic wait_result(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (!out_valid && cycles < 50);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout: out_valid=%b after %0d cycles, required 1", out_valid, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    S1 = 32'hFFFF_FFFF; S2 = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (R !== 32'h0) begin errors++; $display("FAIL reset_R: got %h required 00000000", R); end
    if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b required 0", cout); end
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_idle: in_ready=%b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_carry_ripple();
    int lat;
    out_ready = 1'b1;
    offer(32'h0000_0001, 32'hFFFF_FFFF);
    wait_result(lat);
    checks += 3;
    if (lat != 4) begin errors++; $display("FAIL ripple_latency: got %0d required 4", lat); end
    if (R !== 32'h0) begin errors++; $display("FAIL ripple_R: got %h required 00000000", R); end
    if (cout !== 1'b1) begin errors++; $display("FAIL ripple_cout: got %b required 1", cout); end
    @(negedge clk);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ripple_drop_valid: got %b required 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ripple_ready_back: got %b required 1", in_ready); end
  endtask

  task automatic test_stall();
    int lat;
    out_ready = 1'b0;
    offer(32'h1234_5678, 32'h0FED_CBA8);
    S1 = 32'hDEAD_BEEF; S2 = 32'hCAFE_F00D;
    wait_result(lat);
    checks += 3;
    if (lat != 4) begin errors++; $display("FAIL stall_latency: got %0d required 4", lat); end
    if (R !== 32'h2222_2220) begin errors++; $display("FAIL stall_R: got %h required 22222220", R); end
    if (cout !== 1'b0) begin errors++; $display("FAIL stall_cout: got %b required 0", cout); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      S1 = $urandom; S2 = $urandom;
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b required 1", i, out_valid); end
      if (R !== 32'h2222_2220) begin errors++; $display("FAIL stall_hold_R[%0d]: got %h required 22222220", i, R); end
      if (cout !== 1'b0) begin errors++; $display("FAIL stall_hold_cout[%0d]: got %b required 0", i, cout); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b required 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: out_valid=%b required 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, t0, t1, n;
    out_ready = 1'b1;
    S1 = 32'h0000_00FF; S2 = 32'h0000_0001; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 t0 = cyc;
    S1 = 32'h7FFF_FFFF; S2 = 32'h0000_0001;
    wait_result(lat);
    checks += 2;
    if (R !== 32'h0000_0100) begin errors++; $display("FAIL b2b_first_R: got %h required 00000100", R); end
    if (cout !== 1'b0) begin errors++; $display("FAIL b2b_first_cout: got %b required 0", cout); end
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 t1 = cyc;
    in_valid = 1'b0;
    checks++;
    if (t1 - t0 != 6) begin errors++; $display("FAIL b2b_spacing: got %0d cycles required 6", t1 - t0); end
    wait_result(lat);
    checks += 2;
    if (R !== 32'h8000_0000) begin errors++; $display("FAIL b2b_second_R: got %h required 80000000", R); end
    if (cout !== 1'b0) begin errors++; $display("FAIL b2b_second_cout: got %b required 0", cout); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat;
    out_ready = 1'b1;
    offer(32'h8000_0000, 32'h8000_0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b required 0", out_valid); end
    if (R !== 32'h0) begin errors++; $display("FAIL abort_R: got %h required 00000000", R); end
    if (cout !== 1'b0) begin errors++; $display("FAIL abort_cout: got %b required 0", cout); end
    offer(32'h0000_0003, 32'h0000_0004);
    wait_result(lat);
    checks += 2;
    if (R !== 32'h0000_0007) begin errors++; $display("FAIL abort_new_R: got %h required 00000007", R); end
    if (cout !== 1'b0) begin errors++; $display("FAIL abort_new_cout: got %b required 0", cout); end
    @(negedge clk);
  endtask

  // All three chunkings receive each pair together and must match the 33-bit sum.
  task automatic test_random();
    logic [31:0] a, b;
    logic [32:0] exp;
    logic        d8, d1, d32;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 150; n++) begin
      case (n)
        0: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        1: begin a = 32'hFFFF_FFFF; b = 32'h0000_0001; end
        2: begin a = 32'h0000_0000; b = 32'h0000_0000; end
        3: begin a = 32'h5555_5555; b = 32'hAAAA_AAAB; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      exp = {1'b0, a} + {1'b0, b};
      checks++;
      if ({in_ready, rdy1, rdy32} !== 3'b111) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b required 111", n, {in_ready, rdy1, rdy32});
      end
      S1 = a; S2 = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      d8 = 1'b0; d1 = 1'b0; d32 = 1'b0;
      for (int i = 0; i < 36; i++) begin
        @(negedge clk);
        if (out_valid && !d8) begin
          d8 = 1'b1; checks++;
          if ({cout, R} !== exp) begin errors++; $display("FAIL rand_c8[%0d]: got %h required %h", n, {cout, R}, exp); end
        end
        if (vld1 && !d1) begin
          d1 = 1'b1; checks++;
          if ({co1, r1} !== exp) begin errors++; $display("FAIL rand_c1[%0d]: got %h required %h", n, {co1, r1}, exp); end
        end
        if (vld32 && !d32) begin
          d32 = 1'b1; checks++;
          if ({co32, r32} !== exp) begin errors++; $display("FAIL rand_c32[%0d]: got %h required %h", n, {co32, r32}, exp); end
        end
      end
      checks++;
      if ({d8, d1, d32} !== 3'b111) begin
        errors++;
        $display("FAIL rand_done[%0d]: results seen %b required 111", n, {d8, d1, d32});
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; S1 = '0; S2 = '0;
    @(negedge clk);
    test_reset();
    test_carry_ripple();
    test_stall();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
